data_memory_ctrl: RTL and testbench

Parametrised, byte-addressed data memory with a valid/ready request channel and a valid/ready response channel. It generalises the single-cycle data memory in width, depth and byte-lane writes, and adds configurable wait states, error reporting and a hardware clear sequence after reset. It sits between the processor's MEM stage and the on-chip RAM array.

---
 rtl/data_mem_pkg.sv | 36 +++
 rtl/data_mem_array.sv | 36 +++
 rtl/data_memory_ctrl.sv | 155 +++++++++++++++
 tb/tb_data_memory_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the parametrised data memory controller.
// Holds the FSM state type, default geometry and the byte-address decode helpers.
package data_mem_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned DEPTH_DEF  = 128;
    localparam int unsigned BYTES      = DATA_W_DEF / 8;
    localparam int unsigned OFF_W      = $clog2(BYTES);
    localparam int unsigned IDX_W      = $clog2(DEPTH_DEF);

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StWait,
        StResp
    } state_e;

    // Word index: the field directly above the byte offset.
    function automatic logic [31:0] addr_idx(input logic [63:0] addr,
                                             input int unsigned off_w,
                                             input int unsigned idx_w);
        logic [63:0] mask;
        mask = (64'd1 << idx_w) - 64'd1;
        return 32'((addr >> off_w) & mask);
    endfunction

    // Misaligned (nonzero offset) or out of range (bits above the index field).
    function automatic logic addr_err(input logic [63:0] addr,
                                      input int unsigned off_w,
                                      input int unsigned idx_w);
        logic [63:0] off_mask;
        off_mask = (64'd1 << off_w) - 64'd1;
        return (|(addr & off_mask)) || (|(addr >> (off_w + idx_w)));
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-organised RAM with per-byte write enables and a registered read port.
module data_mem_array #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 128
) (
    input  logic                       clk_i,
    input  logic                       we_i,
    input  logic [$clog2(DEPTH)-1:0]   widx_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic [DATA_W/8-1:0]        be_i,
    input  logic                       rd_en_i,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx_i,
    output logic [DATA_W-1:0]          rd_data_o
);

    localparam int unsigned NumBytes = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned b = 0; b < NumBytes; b++) begin
                if (be_i[b]) begin
                    mem_q[widx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Valid/ready data memory controller: post-reset clear, byte-lane writes,
// configurable wait states and misaligned/out-of-range error responses.
module data_memory_ctrl
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DEPTH       = DEPTH_DEF,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_err,
    output logic                init_done
);

    localparam int unsigned NumBytes = DATA_W / 8;
    localparam int unsigned OffW     = $clog2(NumBytes);
    localparam int unsigned IdxW     = $clog2(DEPTH);
    localparam logic [3:0]  WaitLoad = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic              write_q, write_d;
    logic              err_q, err_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              resp_valid_q, resp_valid_d;
    logic              init_done_q, init_done_d;

    logic [IdxW-1:0]   dec_idx;
    logic              dec_err;

    logic              mem_we;
    logic [IdxW-1:0]   mem_widx;
    logic [DATA_W-1:0] mem_wdata;
    logic [NumBytes-1:0] mem_be;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;

    assign dec_idx = IdxW'(addr_idx(64'(req_addr), OffW, IdxW));
    assign dec_err = addr_err(64'(req_addr), OffW, IdxW);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        idx_d        = idx_q;
        write_d      = write_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        init_done_d  = init_done_q;
        mem_we       = 1'b0;
        mem_widx     = dec_idx;
        mem_wdata    = req_wdata;
        mem_be       = req_be;
        rd_en        = 1'b0;

        unique case (state_q)
            StInit: begin
                mem_we    = 1'b1;
                mem_widx  = ptr_q;
                mem_wdata = '0;
                mem_be    = '1;
                if (ptr_q == IdxW'(DEPTH - 1)) begin
                    state_d     = StIdle;
                    init_done_d = 1'b1;
                end else begin
                    ptr_d = ptr_q + IdxW'(1);
                end
            end
            StIdle: begin
                if (req_valid) begin
                    write_d = req_write;
                    idx_d   = dec_idx;
                    err_d   = dec_err;
                    // Writes commit at acceptance so a later read sees them.
                    mem_we  = req_write && !dec_err;
                    cnt_d   = WaitLoad;
                    state_d = (WAIT_CYCLES > 0) ? StWait : StResp;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (!resp_valid_q) begin
                    // First RESP cycle: capture read data once, then hold it.
                    rd_en        = 1'b1;
                    resp_valid_d = 1'b1;
                end else if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StInit;
            ptr_q        <= '0;
            idx_q        <= '0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            idx_q        <= idx_d;
            write_q      <= write_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            init_done_q  <= init_done_d;
        end
    end

    data_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk_i     (clk),
        .we_i      (mem_we && !rst),
        .widx_i    (mem_widx),
        .wdata_i   (mem_wdata),
        .be_i      (mem_be),
        .rd_en_i   (rd_en),
        .rd_idx_i  (idx_q),
        .rd_data_o (rd_data)
    );

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_valid_q && err_q;
    assign resp_rdata = (resp_valid_q && !write_q && !err_q) ? rd_data : '0;
    assign init_done  = init_done_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: one controller with no wait states, one with three.
module tb_data_memory_ctrl;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] rdata;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_write  [2];
    logic [15:0] req_addr   [2];
    logic [15:0] req_wdata  [2];
    logic [1:0]  req_be     [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [15:0] resp_rdata [2];
    logic        resp_err   [2];
    logic        init_done  [2];

    int n_checks = 0;
    int n_pass   = 0;

    vec_t vecs [15];

    always #5 clk = ~clk;

    data_memory_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(128), .WAIT_CYCLES(0)) u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid[0]),
        .req_ready  (req_ready[0]),
        .req_write  (req_write[0]),
        .req_addr   (req_addr[0]),
        .req_wdata  (req_wdata[0]),
        .req_be     (req_be[0]),
        .resp_valid (resp_valid[0]),
        .resp_ready (resp_ready[0]),
        .resp_rdata (resp_rdata[0]),
        .resp_err   (resp_err[0]),
        .init_done  (init_done[0])
    );

    data_memory_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH(128), .WAIT_CYCLES(3)) u_dut3 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid[1]),
        .req_ready  (req_ready[1]),
        .req_write  (req_write[1]),
        .req_addr   (req_addr[1]),
        .req_wdata  (req_wdata[1]),
        .req_be     (req_be[1]),
        .resp_valid (resp_valid[1]),
        .resp_ready (resp_ready[1]),
        .resp_rdata (resp_rdata[1]),
        .resp_err   (resp_err[1]),
        .init_done  (init_done[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_init(input int d, input string nm);
        int cyc = 0;
        int bad = 0;
        while (!init_done[d] && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!init_done[d] && (req_ready[d] || resp_valid[d])) bad++;
        end
        chk({nm, "_init_cycles"}, cyc, 128);
        chk({nm, "_quiet_during_init"}, bad, 0);
    endtask

    // Full transaction with resp_ready high; latency 1 (no waits) or 4 (three waits).
    task automatic txn(input int d, input string nm, input vec_t v);
        int lat = (d == 0) ? 1 : 4;
        int n = 0;
        @(negedge clk);
        req_write[d] = v.wr;
        req_addr[d]  = v.addr;
        req_wdata[d] = v.wdata;
        req_be[d]    = v.be;
        req_valid[d] = 1'b1;
        while (!req_ready[d] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) begin
            chk({nm, "_ready_timeout"}, 32'(req_ready[d]), 1);
            req_valid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        chk({nm, "_after_accept"}, {30'd0, resp_valid[d], req_ready[d]}, 0);
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk);
            #1;
            if (k < lat) chk({nm, "_stall"}, {30'd0, resp_valid[d], req_ready[d]}, 0);
        end
        chk({nm, "_valid"}, 32'(resp_valid[d]), 1);
        chk({nm, "_rdata"}, 32'(resp_rdata[d]), 32'(v.rdata));
        chk({nm, "_err"}, 32'(resp_err[d]), 32'(v.err));
        @(posedge clk);
        #1;
        chk({nm, "_back_idle"}, {30'd0, resp_valid[d], req_ready[d]}, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 16'h00FE, 16'h0000, 2'b00, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 16'h0010, 16'hBEEF, 2'b11, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBEEF, 1'b0};
        vecs[3]  = '{1'b1, 16'h0010, 16'h1234, 2'b01, 16'h0000, 1'b0};
        vecs[4]  = '{1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBE34, 1'b0};
        vecs[5]  = '{1'b1, 16'h0010, 16'hFFFF, 2'b00, 16'h0000, 1'b0};
        vecs[6]  = '{1'b0, 16'h0010, 16'h0000, 2'b00, 16'hBE34, 1'b0};
        vecs[7]  = '{1'b0, 16'h0011, 16'h0000, 2'b00, 16'h0000, 1'b1};
        vecs[8]  = '{1'b1, 16'h0100, 16'hAAAA, 2'b11, 16'h0000, 1'b1};
        vecs[9]  = '{1'b0, 16'h0000, 16'h0000, 2'b00, 16'h0000, 1'b0};
        vecs[10] = '{1'b1, 16'h0013, 16'h7777, 2'b11, 16'h0000, 1'b1};
        vecs[11] = '{1'b0, 16'h0012, 16'h0000, 2'b00, 16'h0000, 1'b0};
        vecs[12] = '{1'b1, 16'h00FE, 16'h5A5A, 2'b10, 16'h0000, 1'b0};
        vecs[13] = '{1'b0, 16'h00FE, 16'h0000, 2'b00, 16'h5A00, 1'b0};
        vecs[14] = '{1'b0, 16'h8010, 16'h0000, 2'b00, 16'h0000, 1'b1};

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d]  = 1'b0;
            req_write[d]  = 1'b0;
            req_addr[d]   = '0;
            req_wdata[d]  = '0;
            req_be[d]     = '0;
            resp_ready[d] = 1'b1;
        end
        // Read of 0x00FE held pending across reset and the clear sequence.
        req_valid[0] = 1'b1;
        req_addr[0]  = 16'h00FE;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_flags%0d", d),
                {28'd0, req_ready[d], resp_valid[d], resp_err[d], init_done[d]}, 0);
            chk($sformatf("reset_rdata%0d", d), 32'(resp_rdata[d]), 0);
        end
        rst = 1'b0;
        wait_init(0, "dut0");
        chk("dut3_init_done", 32'(init_done[1]), 1);

        for (int i = 0; i < 15; i++) begin
            txn(0, $sformatf("vec%0d", i), vecs[i]);
        end

        // Three wait states, response back-pressured for five cycles.
        txn(1, "w3_write", '{1'b1, 16'h0020, 16'hCAFE, 2'b11, 16'h0000, 1'b0});
        @(negedge clk);
        resp_ready[1] = 1'b0;
        req_write[1]  = 1'b0;
        req_addr[1]   = 16'h0020;
        req_valid[1]  = 1'b1;
        chk("w3_ready_before", 32'(req_ready[1]), 1);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (k < 4) chk($sformatf("w3_stall%0d", k), {30'd0, resp_valid[1], req_ready[1]}, 0);
        end
        chk("w3_valid_edge4", 32'(resp_valid[1]), 1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("w3_hold%0d", c),
                {13'd0, resp_valid[1], req_ready[1], resp_err[1], resp_rdata[1]},
                {13'd0, 1'b1, 1'b0, 1'b0, 16'hCAFE});
        end
        @(negedge clk);
        resp_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        chk("w3_release", {30'd0, resp_valid[1], req_ready[1]}, 1);

        // Reset while a read is waiting: no response, clear sequence re-runs.
        txn(1, "w3_write30", '{1'b1, 16'h0030, 16'h1111, 2'b11, 16'h0000, 1'b0});
        @(negedge clk);
        req_write[1] = 1'b0;
        req_addr[1]  = 16'h0030;
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_wait_flags", {29'd0, resp_valid[1], req_ready[1], init_done[1]}, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_init(1, "dut3_rerun");
        txn(1, "cleared30", '{1'b0, 16'h0030, 16'h0000, 2'b00, 16'h0000, 1'b0});
        txn(1, "cleared20", '{1'b0, 16'h0020, 16'h0000, 2'b00, 16'h0000, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
